// File: rtl/trace_dump_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// trace_dump_sequencer_pkg
//   Shared definitions for the trace/dump engine: record tag codes, halt-cause
//   codes, top-level state encoding, read-stage phase encoding and a small
//   elaboration-time helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package trace_dump_sequencer_pkg;

    typedef enum logic [1:0] {
        TAG_PC  = 2'b00,
        TAG_REG = 2'b01,
        TAG_MEM = 2'b10,
        TAG_END = 2'b11
    } tag_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_HALT    = 2'b01,
        CAUSE_TIMEOUT = 2'b10
    } cause_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DUMP_REG,
        ST_DUMP_MEM,
        ST_END,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_CAPTURE,
        RD_VALID
    } rd_phase_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/trace_read_stage.sv
// -----------------------------------------------------------------------------
// trace_read_stage
//   Walks a block of consecutive addresses of a synchronous-read storage and
//   turns each word into one valid/ready record. Read data arrives one cycle
//   after the address; it is captured into a holding register that stays
//   stable until the consumer accepts it.
// Ports
//   clk          in   clock
//   reset        in   synchronous, active-low reset
//   start_i      in   pulse: load base_i/count_i and issue the first read
//   base_i       in   first address of the block
//   count_i      in   number of words in the block (>=1)
//   rdata_i      in   read data for the address issued in the previous cycle
//   raddr_o      out  read address presented this cycle
//   out_ready_i  in   consumer ready
//   out_valid_o  out  holding register contains a record
//   out_data_o   out  holding register contents
//   last_o       out  final record of the block is accepted this cycle
// -----------------------------------------------------------------------------
module trace_read_stage
    import trace_dump_sequencer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AW     = 16,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [AW-1:0]     base_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [AW-1:0]     raddr_o,
    input  logic              out_ready_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              last_o
);

    rd_phase_e         phase_q, phase_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              fire;

    always_comb begin
        // NOTE: every next-state value defaults to its register first, so no
        // path through the case below can infer a latch.
        phase_d     = phase_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        fire        = (phase_q == RD_VALID) && out_ready_i;
        last_o      = fire && (remaining_q == CNT_W'(1));

        if (start_i) begin
            phase_d     = RD_CAPTURE;
            addr_d      = base_i;
            remaining_d = count_i;
        end else begin
            case (phase_q)
                RD_CAPTURE: begin
                    data_d  = rdata_i;
                    phase_d = RD_VALID;
                end
                RD_VALID: begin
                    if (fire) begin
                        if (last_o) begin
                            phase_d = RD_IDLE;
                        end else begin
                            addr_d      = addr_q + AW'(1);
                            remaining_d = remaining_q - CNT_W'(1);
                            phase_d     = RD_CAPTURE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // The next address goes out in the accepting cycle itself, so its data is
    // ready to capture in the following cycle: two cycles per record.
    assign raddr_o     = addr_d;
    assign out_valid_o = (phase_q == RD_VALID);
    assign out_data_o  = data_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_q     <= RD_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            // NOTE: the holding register is a single word, not a memory, and
            // is cleared so that nothing stale survives a reset.
            data_q      <= '0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            phase_q     <= phase_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
        end
    end

endmodule

// File: rtl/trace_dump_sequencer.sv
// -----------------------------------------------------------------------------
// trace_dump_sequencer
//   Trace/dump engine for the single-cycle datapath machine. While running it
//   streams one PC record per retired cycle; on halt (halt instruction or
//   cycle timeout) it stalls the machine and reads out the register file and
//   a data-memory window, then one END record carrying the run cycle count.
// Ports
//   clk         in   clock, rising edge
//   reset       in   synchronous, active-low reset
//   start       in   level, sampled only in IDLE
//   pc, inst    in   machine PC and instruction at that PC
//   cpu_stall   out  hold machine state this cycle
//   rf_raddr    out  register-file read address  / rf_rdata  in (1-cycle latency)
//   mem_raddr   out  data-memory read address    / mem_rdata in (1-cycle latency)
//   out_valid   out  record valid                / out_ready in
//   out_tag     out  00 PC, 01 REG, 10 MEM, 11 END
//   out_data    out  record payload
//   done        out  dump finished, held until reset
//   halt_cause  out  00 none, 01 halt instruction, 10 timeout
// -----------------------------------------------------------------------------
module trace_dump_sequencer
    import trace_dump_sequencer_pkg::*;
#(
    parameter int                    DATA_W     = 32,
    parameter int                    NUM_REGS   = 32,
    parameter int                    MEM_ADDR_W = 16,
    parameter logic [MEM_ADDR_W-1:0] MEM_BASE   = 16'h4000,
    parameter int                    MEM_WORDS  = 4,
    parameter logic [DATA_W-1:0]     HALT_INST  = '0,
    parameter int                    TIMEOUT    = 64,
    parameter int                    TRACE_PC   = 1,
    localparam int                   RF_AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     pc,
    input  logic [DATA_W-1:0]     inst,
    output logic                  cpu_stall,
    output logic [RF_AW-1:0]      rf_raddr,
    input  logic [DATA_W-1:0]     rf_rdata,
    output logic [MEM_ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            out_tag,
    output logic [DATA_W-1:0]     out_data,
    output logic                  done,
    output logic [1:0]            halt_cause
);

    // One read stage serves both phases, so its address is wide enough for either.
    localparam int AW    = max_int(RF_AW, MEM_ADDR_W);
    localparam int CNT_W = $clog2(max_int(NUM_REGS, MEM_WORDS) + 1);
    localparam int CYC_W = $clog2(TIMEOUT + 1);

    state_e           state_q;
    cause_e           cause_q;
    logic [CYC_W-1:0] cycles_q;
    logic             done_q;

    logic              run_step, halt_inst, halt_time, halt_now;
    logic              start_reg, start_mem;
    logic              rd_start, rd_valid, rd_last;
    logic [AW-1:0]     rd_base, rd_raddr;
    logic [CNT_W-1:0]  rd_count;
    logic [DATA_W-1:0] rd_rdata, rd_data;

    // Output mux and stall. The PC record is combinational from pc so the
    // machine only loses a cycle when the consumer is not ready.
    always_comb begin
        out_valid = 1'b0;
        out_tag   = TAG_PC;
        out_data  = '0;
        cpu_stall = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (TRACE_PC != 0) begin
                    out_valid = 1'b1;
                    out_data  = pc;
                end
                cpu_stall = out_valid & ~out_ready;
            end
            ST_DUMP_REG: begin
                out_valid = rd_valid;
                out_tag   = TAG_REG;
                out_data  = rd_data;
                cpu_stall = 1'b1;
            end
            ST_DUMP_MEM: begin
                out_valid = rd_valid;
                out_tag   = TAG_MEM;
                out_data  = rd_data;
                cpu_stall = 1'b1;
            end
            ST_END: begin
                out_valid = 1'b1;
                out_tag   = TAG_END;
                out_data  = DATA_W'(cycles_q);
                cpu_stall = 1'b1;
            end
            ST_DONE: cpu_stall = 1'b1;
            default: ;
        endcase
    end

    // Counting and halt detection only happen on cycles the machine retires.
    assign run_step  = (state_q == ST_RUN) && !cpu_stall;
    assign halt_inst = (inst == HALT_INST);
    assign halt_time = (cycles_q == CYC_W'(TIMEOUT - 1));
    assign halt_now  = run_step && (halt_inst || halt_time);

    // The register read is issued in the halting cycle and the memory read in
    // the cycle the last register record is accepted, so no idle cycle is lost.
    assign start_reg = halt_now;
    assign start_mem = (state_q == ST_DUMP_REG) && rd_last && (MEM_WORDS != 0);
    assign rd_start  = start_reg || start_mem;
    assign rd_base   = start_mem ? AW'(MEM_BASE) : '0;
    assign rd_count  = start_mem ? CNT_W'(MEM_WORDS) : CNT_W'(NUM_REGS);
    assign rd_rdata  = (state_q == ST_DUMP_MEM) ? mem_rdata : rf_rdata;

    // Memory addresses wrap naturally by keeping only the low MEM_ADDR_W bits.
    assign rf_raddr  = (start_reg || (state_q == ST_DUMP_REG && !start_mem))
                       ? rd_raddr[RF_AW-1:0] : '0;
    assign mem_raddr = (start_mem || state_q == ST_DUMP_MEM)
                       ? rd_raddr[MEM_ADDR_W-1:0] : '0;

    assign done       = done_q;
    assign halt_cause = cause_q;

    trace_read_stage #(
        .DATA_W (DATA_W),
        .AW     (AW),
        .CNT_W  (CNT_W)
    ) u_read (
        .clk         (clk),
        .reset       (reset),
        .start_i     (rd_start),
        .base_i      (rd_base),
        .count_i     (rd_count),
        .rdata_i     (rd_rdata),
        .raddr_o     (rd_raddr),
        .out_ready_i (out_ready),
        .out_valid_o (rd_valid),
        .out_data_o  (rd_data),
        .last_o      (rd_last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cause_q  <= CAUSE_NONE;
            cycles_q <= '0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (run_step) begin
                        cycles_q <= cycles_q + CYC_W'(1);
                        if (halt_now) begin
                            // Halt instruction wins when both fire together.
                            cause_q <= halt_inst ? CAUSE_HALT : CAUSE_TIMEOUT;
                            state_q <= ST_DUMP_REG;
                        end
                    end
                end
                ST_DUMP_REG: begin
                    if (rd_last) state_q <= (MEM_WORDS != 0) ? ST_DUMP_MEM : ST_END;
                end
                ST_DUMP_MEM: begin
                    if (rd_last) state_q <= ST_END;
                end
                ST_END: begin
                    if (out_ready) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: ;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_dump_sequencer.sv
// -----------------------------------------------------------------------------
// tb_trace_dump_sequencer
//   Scoreboard bench. The main process drives a small machine model and pushes
//   the records it expects; negedge monitors pop and compare every accepted
//   record. A second instance covers memory-window address wrap.
// -----------------------------------------------------------------------------
module tb_trace_dump_sequencer;
    import trace_dump_sequencer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (default parameters)
    logic        reset, start, out_ready;
    logic [31:0] pc, inst;
    logic        cpu_stall, out_valid, done;
    logic [4:0]  rf_raddr;
    logic [15:0] mem_raddr;
    logic [31:0] rf_rdata, mem_rdata, out_data;
    logic [1:0]  out_tag, halt_cause;

    // Wrap instance: 4 registers, memory window starting at 0xFFFE
    logic        start_b, out_ready_b;
    logic [31:0] pc_b, inst_b;
    logic        cpu_stall_b, out_valid_b, done_b;
    logic [1:0]  rf_raddr_b;
    logic [15:0] mem_raddr_b;
    logic [31:0] rf_rdata_b, mem_rdata_b, out_data_b;
    logic [1:0]  out_tag_b, halt_cause_b;

    trace_dump_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .pc(pc), .inst(inst),
        .cpu_stall(cpu_stall), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_tag(out_tag), .out_data(out_data),
        .done(done), .halt_cause(halt_cause)
    );

    trace_dump_sequencer #(
        .NUM_REGS(4), .MEM_BASE(16'hFFFE), .MEM_WORDS(4), .TIMEOUT(8)
    ) dut_wrap (
        .clk(clk), .reset(reset), .start(start_b), .pc(pc_b), .inst(inst_b),
        .cpu_stall(cpu_stall_b), .rf_raddr(rf_raddr_b), .rf_rdata(rf_rdata_b),
        .mem_raddr(mem_raddr_b), .mem_rdata(mem_rdata_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_tag(out_tag_b), .out_data(out_data_b),
        .done(done_b), .halt_cause(halt_cause_b)
    );

    // Storage models: synchronous read, data one cycle after the address.
    function automatic logic [31:0] rf_val(input logic [4:0] a);
        return 32'hC0DE_0000 | {27'd0, a};
    endfunction
    function automatic logic [31:0] mem_val(input logic [15:0] a);
        return {16'hD00D, a};
    endfunction

    always @(posedge clk) begin
        rf_rdata    <= rf_val(rf_raddr);
        mem_rdata   <= mem_val(mem_raddr);
        rf_rdata_b  <= rf_val({3'd0, rf_raddr_b});
        mem_rdata_b <= mem_val(mem_raddr_b);
    end

    // Machine model: pc steps by 4 whenever a PC record is accepted.
    int          pc_idx;
    int          halt_idx;
    logic [31:0] pc_base;
    assign pc     = pc_base + 32'(pc_idx * 4);
    assign inst   = (pc_idx == halt_idx) ? 32'h0 : 32'h0000_0013;
    assign pc_b   = 32'h0000_0200;
    assign inst_b = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] got);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got 0x%0h with nothing expected", name, got);
    endtask

    // Scoreboards
    logic [33:0] sb[$];
    logic [33:0] sb_b[$];

    task automatic push_run(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) sb.push_back({TAG_PC, base + 32'(i * 4)});
    endtask

    task automatic push_dump(input int cycles);
        for (int r = 0; r < 32; r++) sb.push_back({TAG_REG, rf_val(5'(r))});
        for (int m = 0; m < 4; m++) sb.push_back({TAG_MEM, mem_val(16'h4000 + 16'(m))});
        sb.push_back({TAG_END, 32'(cycles)});
    endtask

    // Monitors (sampled on the falling edge, away from the active edge)
    bit          cpu_adv;
    int          reg_seen;
    bit          hold_q;
    logic [33:0] held;

    always @(negedge clk) begin
        logic [33:0] exp;
        cpu_adv = 1'b0;
        if (reset !== 1'b1) begin
            hold_q = 1'b0;
        end else begin
            if (hold_q)
                check("stalled_record_held", 64'({out_valid, out_tag, out_data}), 64'({1'b1, held}));
            if (out_valid)
                check("cpu_stall", 64'(cpu_stall),
                      64'((out_tag == TAG_PC) ? !out_ready : 1'b1));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_record", 64'({out_tag, out_data}));
                end else begin
                    exp = sb.pop_front();
                    check("record", 64'({out_tag, out_data}), 64'(exp));
                end
                if (out_tag == TAG_PC)  cpu_adv = 1'b1;
                if (out_tag == TAG_REG) reg_seen++;
            end
            hold_q = out_valid && !out_ready;
            held   = {out_tag, out_data};
        end
    end

    always @(negedge clk) begin
        logic [33:0] exp;
        if (reset === 1'b1 && out_valid_b && out_ready_b) begin
            if (sb_b.size() == 0) begin
                fail_now("wrap_unexpected_record", 64'({out_tag_b, out_data_b}));
            end else begin
                exp = sb_b.pop_front();
                check("wrap_record", 64'({out_tag_b, out_data_b}), 64'(exp));
            end
        end
    end

    // Stimulus helpers
    bit toggle;

    task automatic tick();
        @(posedge clk);
        #1;
        if (cpu_adv) pc_idx++;
        if (toggle) out_ready = ~out_ready;
    endtask

    task automatic check_zero(input string name);
        check(name, 64'({out_valid, cpu_stall, out_tag, out_data, done, halt_cause,
                         rf_raddr, mem_raddr}), 64'(0));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        check_zero("reset_outputs");
        reset = 1'b1;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({name, "_done"}, 64'(done), 64'(1));
        check({name, "_sb_empty"}, 64'(sb.size()), 64'(0));
    endtask

    task automatic run_prog(input logic [31:0] base, input int halt_at, input int n_pc);
        pc_base  = base;
        halt_idx = halt_at;
        pc_idx   = 0;
        push_run(base, n_pc);
    endtask

    initial begin
        int seen0;
        reset = 1'b0; start = 1'b1; start_b = 1'b1;
        out_ready = 1'b1; out_ready_b = 1'b1; toggle = 1'b0;
        reg_seen = 0;

        // 1) reset held with start=1, then halt-instruction program 0x0,0x4,0x8
        run_prog(32'h0, 2, 3);
        push_dump(3);
        sb_b.push_back({TAG_PC, 32'h0000_0200});
        for (int r = 0; r < 4; r++) sb_b.push_back({TAG_REG, rf_val(5'(r))});
        sb_b.push_back({TAG_MEM, mem_val(16'hFFFE)});
        sb_b.push_back({TAG_MEM, mem_val(16'hFFFF)});
        sb_b.push_back({TAG_MEM, mem_val(16'h0000)});
        sb_b.push_back({TAG_MEM, mem_val(16'h0001)});
        sb_b.push_back({TAG_END, 32'd1});

        for (int i = 0; i < 3; i++) begin
            tick();
            check_zero("reset_hold_outputs");
        end
        check("wrap_reset_valid", 64'(out_valid_b), 64'(0));
        reset = 1'b1;
        tick();
        check("run_after_release", 64'({out_valid, out_tag, out_data}), 64'({1'b1, TAG_PC, 32'h0}));
        start = 1'b0; start_b = 1'b0;
        wait_done(500, "halt_prog");
        check("halt_prog_cause", 64'(halt_cause), 64'(CAUSE_HALT));
        check("wrap_done", 64'(done_b), 64'(1));
        check("wrap_cause", 64'(halt_cause_b), 64'(CAUSE_HALT));
        check("wrap_sb_empty", 64'(sb_b.size()), 64'(0));
        start = 1'b1;
        tick();
        tick();
        check("done_ignores_start", 64'({done, out_valid, cpu_stall}), 64'(3'b101));
        start = 1'b0;

        // 2) never-halting program: timeout after exactly 64 PC records
        run_prog(32'h1000, -1, 64);
        push_dump(64);
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1000, "timeout");
        check("timeout_cause", 64'(halt_cause), 64'(CAUSE_TIMEOUT));

        // 3) out_ready toggling every cycle through run and dump
        run_prog(32'h20, 4, 5);
        push_dump(5);
        do_reset();
        out_ready = 1'b0;
        toggle    = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        wait_done(2000, "toggle");
        toggle    = 1'b0;
        out_ready = 1'b1;
        check("toggle_cause", 64'(halt_cause), 64'(CAUSE_HALT));

        // 4) reset during DUMP_REG right after r5 is accepted, then rerun
        run_prog(32'h40, 0, 1);
        for (int r = 0; r < 6; r++) sb.push_back({TAG_REG, rf_val(5'(r))});
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        seen0 = reg_seen;
        for (int n = 0; n < 200 && (reg_seen - seen0) < 6; n++) tick();
        check("abort_regs_seen", 64'(reg_seen - seen0), 64'(6));
        reset = 1'b0;
        tick();
        check_zero("abort_outputs");
        check("abort_sb_empty", 64'(sb.size()), 64'(0));
        tick();
        reset = 1'b1;
        run_prog(32'h0, 2, 3);
        push_dump(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(500, "rerun");
        check("rerun_cause", 64'(halt_cause), 64'(CAUSE_HALT));

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
